div_unit: RTL and testbench

Iterative 32-bit MIPS integer divider that sits directly upstream of the HI/LO register file and executes DIV and DIVU. The execute stage launches an operation with a start pulse. The unit produces one quotient bit per cycle, then presents the quotient on `lo_o` and the remainder on `hi_o` with a one-cycle valid strobe. That strobe drives the HI/LO write-enable through the pipeline. A cancel input annuls an in-flight divide on pipeline flush or exception.

---
 rtl/div_unit.sv | 149 ++++++++++++++
 tb/tb_div_unit.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/div_unit.sv
// div_unit: iterative 32-bit restoring divider (MIPS DIV/DIVU) feeding the HI/LO register file.
// Optional DIV_ZERO_FAST_EN: a divisor-zero launch bypasses the iteration loop.
module div_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_i,
    input  logic        signed_i,
    input  logic [31:0] opdata1_i,
    input  logic [31:0] opdata2_i,
    input  logic        cancel_i,
    output logic        ready_o,
    output logic        result_valid_o,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DIV  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [5:0]  cnt;
    logic [32:0] rem;
    logic [31:0] quo;
    logic [31:0] dvsr;
    logic        quo_sign;
    logic        rem_sign;

    logic        neg1;
    logic        neg2;
    logic [31:0] mag1;
    logic [31:0] mag2;
    logic        launch;
    logic        iterate;
    logic        last_iter;
    logic [33:0] shifted;
    logic [33:0] trial;
    logic [32:0] rem_next;
    logic [31:0] quo_next;
    logic [31:0] quo_fix;
    logic [31:0] rem_fix;
`ifdef DIV_ZERO_FAST_EN
    logic        div_zero;
`endif

    // Operand magnitudes and control qualifiers
    always_comb begin
        neg1      = signed_i & opdata1_i[31];
        neg2      = signed_i & opdata2_i[31];
        mag1      = neg1 ? (~opdata1_i + 32'd1) : opdata1_i;
        mag2      = neg2 ? (~opdata2_i + 32'd1) : opdata2_i;
        launch    = (state == IDLE) && start_i && !cancel_i;
        iterate   = (state == DIV) && !cancel_i;
        last_iter = iterate && (cnt == 6'd31);
`ifdef DIV_ZERO_FAST_EN
        div_zero  = (opdata2_i == '0);
`endif
    end

    // One restoring step; the final step's result is sign-corrected and registered
    // straight onto hi/lo so it is visible in the DONE cycle.
    always_comb begin
        shifted = {rem, quo[31]};
        trial   = shifted - {2'b00, dvsr};
        if (!trial[33]) begin
            rem_next = trial[32:0];
            quo_next = {quo[30:0], 1'b1};
        end else begin
            rem_next = shifted[32:0];
            quo_next = {quo[30:0], 1'b0};
        end
        quo_fix = quo_sign ? (~quo_next + 32'd1) : quo_next;
        rem_fix = rem_sign ? (~rem_next[31:0] + 32'd1) : rem_next[31:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start_i) begin
`ifdef DIV_ZERO_FAST_EN
                    state_next = div_zero ? DONE : DIV;
`else
                    state_next = DIV;
`endif
                end
            end
            DIV: begin
                if (cnt == 6'd31) begin
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (cancel_i) begin
            state_next = IDLE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt      <= '0;
            rem      <= '0;
            quo      <= '0;
            dvsr     <= '0;
            quo_sign <= 1'b0;
            rem_sign <= 1'b0;
            hi_o     <= '0;
            lo_o     <= '0;
        end else if (launch) begin
            cnt      <= '0;
            rem      <= '0;
            quo      <= mag1;
            dvsr     <= mag2;
            quo_sign <= neg1 ^ neg2;
            rem_sign <= neg1;
`ifdef DIV_ZERO_FAST_EN
            if (div_zero) begin
                hi_o <= opdata1_i;
                lo_o <= '1;
            end
`endif
        end else if (iterate) begin
            cnt <= cnt + 6'd1;
            rem <= rem_next;
            quo <= quo_next;
            if (last_iter) begin
                hi_o <= rem_fix;
                lo_o <= quo_fix;
            end
        end
    end

    assign ready_o        = (state == IDLE);
    assign result_valid_o = (state == DONE);

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed corner cases plus random operands
// compared against an arithmetic reference model.
module tb_div_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_i;
    logic        signed_i;
    logic [31:0] opdata1_i;
    logic [31:0] opdata2_i;
    logic        cancel_i;
    logic        ready_o;
    logic        result_valid_o;
    logic [31:0] hi_o;
    logic [31:0] lo_o;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    div_unit dut (
        .clk            (clk),
        .rst            (rst),
        .start_i        (start_i),
        .signed_i       (signed_i),
        .opdata1_i      (opdata1_i),
        .opdata2_i      (opdata2_i),
        .cancel_i       (cancel_i),
        .ready_o        (ready_o),
        .result_valid_o (result_valid_o),
        .hi_o           (hi_o),
        .lo_o           (lo_o)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: plain 64-bit integer division with truncation toward zero.
    task automatic model(input logic s, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] q, output logic [31:0] r, output int lat);
        longint sa;
        longint sb;
        longint lq;
        longint lr;
        lat = 33;
        if (b == 32'd0) begin
            r = a;
            q = 32'hFFFF_FFFF;
`ifdef DIV_ZERO_FAST_EN
            lat = 1;
`else
            if (s && a[31]) q = 32'd1;
`endif
        end else begin
            if (s) begin
                sa = longint'($signed(a));
                sb = longint'($signed(b));
            end else begin
                sa = longint'({32'd0, a});
                sb = longint'({32'd0, b});
            end
            lq = sa / sb;
            lr = sa % sb;
            q  = lq[31:0];
            r  = lr[31:0];
        end
    endtask

    // Called at posedge+1 with the unit idle; returns at posedge+1 with the unit idle again.
    task automatic do_op(input logic s, input logic [31:0] a, input logic [31:0] b, input string tag);
        logic [31:0] eq;
        logic [31:0] er;
        int          lat;
        int          n;
        model(s, a, b, eq, er, lat);
        signed_i  = s;
        opdata1_i = a;
        opdata2_i = b;
        start_i   = 1'b1;
        @(posedge clk); #1;
        start_i   = 1'b0;
        opdata1_i = $urandom;
        opdata2_i = $urandom;
        signed_i  = 1'($urandom_range(0, 1));
        n = 1;
        while (result_valid_o !== 1'b1 && n < 40) begin
            if (lat == 33 && n == 5) start_i = 1'b1;
            if (n == 6) start_i = 1'b0;
            @(posedge clk); #1;
            n++;
        end
        start_i = 1'b0;
        check({tag, "_latency"}, n, lat);
        check({tag, "_lo"}, lo_o, eq);
        check({tag, "_hi"}, hi_o, er);
        check({tag, "_ready_busy"}, 32'(ready_o), 32'd0);
        @(posedge clk); #1;
        check({tag, "_ready_after"}, 32'(ready_o), 32'd1);
        check({tag, "_valid_after"}, 32'(result_valid_o), 32'd0);
    endtask

    initial begin
        logic        s;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hold_hi;
        logic [31:0] hold_lo;
        int          saw_valid;
        int          n;

        rst       = 1'b0;
        start_i   = 1'b0;
        signed_i  = 1'b0;
        opdata1_i = '0;
        opdata2_i = '0;
        cancel_i  = 1'b0;
        #1 rst = 1'b1;
        #2;
        check("reset_ready", 32'(ready_o), 32'd1);
        check("reset_valid", 32'(result_valid_o), 32'd0);
        check("reset_hi", hi_o, 32'd0);
        check("reset_lo", lo_o, 32'd0);
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;

        do_op(1'b0, 32'd100, 32'd7, "divu_100_7");
        do_op(1'b1, 32'hFFFF_FFF9, 32'd2, "div_m7_2");
        do_op(1'b1, 32'd7, 32'hFFFF_FFFE, "div_7_m2");
        do_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, "div_min_m1");
        do_op(1'b0, 32'hFFFF_FFFF, 32'd1, "divu_max_1");
        do_op(1'b1, 32'hFFFF_FFFB, 32'd0, "div_m5_0");
        do_op(1'b0, 32'h0000_1234, 32'd0, "divu_x_0");
        do_op(1'b1, 32'h8000_0000, 32'd0, "div_min_0");
        do_op(1'b0, 32'hFFFF_FFFF, 32'h8000_0000, "divu_max_min");
        do_op(1'b1, 32'h8000_0000, 32'h8000_0000, "div_min_min");

        // Cancel mid-divide: no strobe, hi/lo untouched, relaunch at cycle 11
        do_op(1'b0, 32'd100, 32'd7, "pre_cancel");
        hold_hi   = hi_o;
        hold_lo   = lo_o;
        saw_valid = 0;
        signed_i  = 1'b0;
        opdata1_i = 32'd500;
        opdata2_i = 32'd3;
        start_i   = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
        n = 1;
        while (n < 10) begin
            @(posedge clk); #1;
            n++;
            if (result_valid_o === 1'b1) saw_valid++;
        end
        cancel_i = 1'b1;
        @(posedge clk); #1;
        cancel_i = 1'b0;
        if (result_valid_o === 1'b1) saw_valid++;
        check("cancel_ready", 32'(ready_o), 32'd1);
        check("cancel_no_valid", 32'(saw_valid), 32'd0);
        check("cancel_hi_hold", hi_o, hold_hi);
        check("cancel_lo_hold", lo_o, hold_lo);
        do_op(1'b0, 32'd1000, 32'd9, "after_cancel");

        // Cancel on the final iteration must suppress the DONE strobe
        hold_hi   = hi_o;
        hold_lo   = lo_o;
        saw_valid = 0;
        signed_i  = 1'b1;
        opdata1_i = 32'hFFFF_FF00;
        opdata2_i = 32'd3;
        start_i   = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
        n = 1;
        while (n < 32) begin
            @(posedge clk); #1;
            n++;
            if (result_valid_o === 1'b1) saw_valid++;
        end
        cancel_i = 1'b1;
        @(posedge clk); #1;
        cancel_i = 1'b0;
        if (result_valid_o === 1'b1) saw_valid++;
        check("late_cancel_ready", 32'(ready_o), 32'd1);
        check("late_cancel_no_valid", 32'(saw_valid), 32'd0);
        check("late_cancel_hi_hold", hi_o, hold_hi);
        check("late_cancel_lo_hold", lo_o, hold_lo);

        // Async reset mid-operation
        do_op(1'b1, 32'hFFFF_FFF9, 32'd2, "pre_reset");
        signed_i  = 1'b0;
        opdata1_i = 32'd100;
        opdata2_i = 32'd7;
        start_i   = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
        repeat (19) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        #1;
        check("midreset_ready", 32'(ready_o), 32'd1);
        check("midreset_valid", 32'(result_valid_o), 32'd0);
        check("midreset_hi", hi_o, 32'd0);
        check("midreset_lo", lo_o, 32'd0);
        @(negedge clk) rst = 1'b0;
        saw_valid = 0;
        repeat (16) begin
            @(posedge clk); #1;
            if (result_valid_o === 1'b1) saw_valid++;
        end
        check("postreset_no_valid", 32'(saw_valid), 32'd0);
        check("postreset_ready", 32'(ready_o), 32'd1);

        for (int i = 0; i < 24; i++) begin
            s = 1'($urandom_range(0, 1));
            a = $urandom;
            if ($urandom_range(0, 7) == 0) a = 32'h8000_0000;
            case ($urandom_range(0, 5))
                0:       b = 32'd0;
                1:       b = 32'($urandom_range(1, 15));
                2:       b = 32'd0 - 32'($urandom_range(1, 15));
                default: b = $urandom;
            endcase
            do_op(s, a, b, $sformatf("rand%0d", i));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL watchdog timeout");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "timeout");
    end

endmodule
